alu_arbiter: RTL and testbench
==============================

Name: alu_arbiter

Overview:
- Shares the single ALU instance between two requesters: pipeline EX stage on port 0, and an auxiliary requester (e.g. debug/address-gen unit) on port 1.
- Accepts one operation at a time over a valid/ready handshake and arbitrates round-robin.
- Drives the ALU operand and control inputs from registers, waits a per-opcode latency (multi-cycle for mul), captures the result, and returns it to the owning requester over a valid/ready response channel.

Parameters:
- WIDTH, 32, operand/result width; must match the ALU data width.
- MUL_LAT, 3, cycles the mul opcode (3'b100) is held in EXEC; legal range 1..15.

Ports:
- clk_i  input  1  clock
- rst_i  input  1  asynchronous reset, active-high
- req0_valid_i  input  1  requester 0 has an op
- req0_ready_o  output  1  requester 0 op accepted this cycle when valid&ready
- req0_data1_i  input  WIDTH  operand 1
- req0_data2_i  input  WIDTH  operand 2
- req0_ctrl_i  input  3  ALU control code
- resp0_valid_o  output  1  result available for requester 0
- resp0_ready_i  input  1  requester 0 consumes result
- resp0_data_o  output  WIDTH  result
- req1_* / resp1_*  same set as port 0, for requester 1
- alu_data1_o  output  WIDTH  to ALU data1_i
- alu_data2_o  output  WIDTH  to ALU data2_i
- alu_ctrl_o  output  3  to ALU ALUCtrl_i
- alu_data_i  input  WIDTH  from ALU data_o

Behaviour:
- Reset (async, rst_i=1): state=IDLE, operand regs=0, alu_ctrl_o=3'b000, result reg=0, owner=0, last_grant=1 (port 0 wins first tie), cycle counter=0. All resp*_valid_o=0 and req*_ready_o=0 while rst_i is high.
- States: IDLE, EXEC, RESP.
- IDLE: grant is combinational.
  - Only one valid: grant that port.
  - Both valid: grant the port != last_grant.
  - reqN_ready_o = (state==IDLE) && grant==N; the other port's ready stays 0. Ready may depend on valid; valid must never depend on ready.
  - On handshake (cycle 0): latch data1/data2/ctrl into operand regs, owner=N, last_grant=N, counter=latency-1, go to EXEC.
  - Latency = MUL_LAT for ctrl 3'b100, 1 otherwise.
- EXEC: operand regs drive alu_* outputs.
  - If counter==0: capture the result on that edge and go to RESP.
  - Otherwise decrement the counter.
  - The captured value is alu_data_i, except for unused code 3'b101, which captures 0.
  - EXEC spans cycles 1..latency.
- RESP: respOwner_valid_o=1 and respOwner_data_o=result from cycle latency+1; the non-owner resp valid stays 0.
  - Valid and data hold stable until respOwner_ready_i=1; that edge returns the FSM to IDLE.
  - No new request is accepted in the same cycle as the response handshake.
  - Minimum occupancy: latency+2 cycles per op.
- Request inputs are ignored outside IDLE; requesters must hold valid and payload until ready.
- resp*_data_o outputs the result reg continuously; it is meaningful only while valid.
- alu_* outputs keep the last operands in IDLE/RESP; no toggling when idle.
- Widths: no extension or truncation; the ALU result is passed through unmodified.
- Reset mid-operation: the in-flight op is dropped, no response is issued, and all state returns to reset values on the asserting edge.

Decomposition:
- Shared package alu_pkg holds:
  - ALU control constants: ALU_AND=3'b000, ALU_SRA=3'b001, ALU_ADD=3'b010, ALU_SLL=3'b011, ALU_MUL=3'b100, ALU_SUB=3'b110, ALU_XOR=3'b111.
  - Arbiter state enum {IDLE, EXEC, RESP}.
  - Default WIDTH.
- One natural sub-module: rr_arb2, a combinational 2-way round-robin grant taking (valid0, valid1, last_grant) and returning grant index + grant_valid. Counter, FSM and datapath regs stay in alu_arbiter.

Test Plan:
- Single add on port 0: data1=5, data2=7, ctrl=3'b010 accepted at cycle 0.
  -> alu_ctrl_o=010 in cycle 1; resp0_valid_o=1 with data 12 at cycle 2; resp1_valid_o stays 0.
- Mul latency, MUL_LAT=3: port 1 sends 6*7, ctrl 3'b100.
  -> resp1_valid_o rises exactly at cycle 4 with data 42.
  -> Repeat with resp1_ready_i low for 5 cycles: data holds at 42, then IDLE one cycle after ready.
- Tie and fairness: both ports valid continuously with sub ops (10-3 on port 0, 9-4 on port 1) after reset.
  -> Grants alternate 0,1,0,1; results 7,5,7,5 land on the correct port.
  -> The non-granted port never sees ready=1.
- Busy blocking: port 0 is in EXEC when port 1 raises valid.
  -> req1_ready_o=0 until FSM returns to IDLE; port 1 is then granted, since last_grant=0.
- Unused code: ctrl=3'b101 with operands 1,1.
  -> Single-cycle latency; response data 0.
- Reset mid-mul: assert rst_i in cycle 2 of a mul.
  -> All valid/ready drop asynchronously; no response after release.
  -> The next tie goes to port 0.

Source files
------------

// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the ALU sharing logic.
// Holds the ALU control codes, the arbiter state enum, the default
// datapath width and a helper that turns an opcode into the number of
// extra EXEC cycles it needs.
package alu_pkg;

  localparam int DEFAULT_WIDTH = 32;

  localparam logic [2:0] ALU_AND    = 3'b000;
  localparam logic [2:0] ALU_SRA    = 3'b001;
  localparam logic [2:0] ALU_ADD    = 3'b010;
  localparam logic [2:0] ALU_SLL    = 3'b011;
  localparam logic [2:0] ALU_MUL    = 3'b100;
  localparam logic [2:0] ALU_UNUSED = 3'b101;
  localparam logic [2:0] ALU_SUB    = 3'b110;
  localparam logic [2:0] ALU_XOR    = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } arb_state_e;

  // The cycle counter is loaded with latency-1 so that reaching zero marks
  // the final EXEC cycle; mul is the only multi-cycle opcode.
  function automatic logic [3:0] op_latency_m1(input logic [2:0] ctrl,
                                                input int mul_lat);
    return (ctrl == ALU_MUL) ? 4'(mul_lat - 1) : 4'd0;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: combinational two-way round-robin grant.
// Ports:
//   valid0, valid1 : request pending on port 0 / port 1
//   last_grant     : port that won the previous grant
//   grant          : index of the granted port (meaningful when grant_valid)
//   grant_valid    : at least one port is requesting
module rr_arb2 (
  input  logic valid0,
  input  logic valid1,
  input  logic last_grant,
  output logic grant,
  output logic grant_valid
);

  // A lone requester always wins; on a tie the port that did not win
  // last time gets the grant so neither side can be starved.
  always_comb begin
    grant       = 1'b0;
    grant_valid = valid0 | valid1;
    if (valid0 && valid1) begin
      grant = ~last_grant;
    end else if (valid1) begin
      grant = 1'b1;
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one ALU between two requesters.
// Takes one op at a time over a valid/ready handshake (round-robin on ties),
// drives the ALU from registered operands, waits the opcode latency, captures
// the result and returns it to the owning requester over valid/ready.
// Ports:
//   clk_i, rst_i                 : clock, async active-high reset
//   reqN_valid_i/reqN_ready_o    : request handshake, port N
//   reqN_data1_i/data2_i/ctrl_i  : request payload, port N
//   respN_valid_o/respN_ready_i  : response handshake, port N
//   respN_data_o                 : result for port N
//   alu_data1_o/data2_o/ctrl_o   : operands and control to the shared ALU
//   alu_data_i                   : result from the shared ALU
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int WIDTH   = DEFAULT_WIDTH,
  parameter int MUL_LAT = 3
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             req0_valid_i,
  output logic             req0_ready_o,
  input  logic [WIDTH-1:0] req0_data1_i,
  input  logic [WIDTH-1:0] req0_data2_i,
  input  logic [2:0]       req0_ctrl_i,
  output logic             resp0_valid_o,
  input  logic             resp0_ready_i,
  output logic [WIDTH-1:0] resp0_data_o,
  input  logic             req1_valid_i,
  output logic             req1_ready_o,
  input  logic [WIDTH-1:0] req1_data1_i,
  input  logic [WIDTH-1:0] req1_data2_i,
  input  logic [2:0]       req1_ctrl_i,
  output logic             resp1_valid_o,
  input  logic             resp1_ready_i,
  output logic [WIDTH-1:0] resp1_data_o,
  output logic [WIDTH-1:0] alu_data1_o,
  output logic [WIDTH-1:0] alu_data2_o,
  output logic [2:0]       alu_ctrl_o,
  input  logic [WIDTH-1:0] alu_data_i
);

  arb_state_e       state;
  logic [WIDTH-1:0] op_data1;
  logic [WIDTH-1:0] op_data2;
  logic [2:0]       op_ctrl;
  logic [WIDTH-1:0] result;
  logic             owner;
  logic             last_grant;
  logic [3:0]       count;

  logic             grant;
  logic             grant_valid;
  logic [WIDTH-1:0] sel_data1;
  logic [WIDTH-1:0] sel_data2;
  logic [2:0]       sel_ctrl;
  logic             accept;
  logic             owner_resp_ready;

  rr_arb2 u_rr_arb2 (
    .valid0      (req0_valid_i),
    .valid1      (req1_valid_i),
    .last_grant  (last_grant),
    .grant       (grant),
    .grant_valid (grant_valid)
  );

  // Payload of whichever port currently holds the grant.
  assign sel_data1 = grant ? req1_data1_i : req0_data1_i;
  assign sel_data2 = grant ? req1_data2_i : req0_data2_i;
  assign sel_ctrl  = grant ? req1_ctrl_i  : req0_ctrl_i;

  // Ready is offered only in IDLE and only to the granted port; it is
  // forced low while reset is held so nothing can be accepted then.
  assign accept       = (state == IDLE) && grant_valid;
  assign req0_ready_o = !rst_i && accept && !grant;
  assign req1_ready_o = !rst_i && accept &&  grant;

  // Response side: only the owner sees valid; data mirrors the result reg.
  assign resp0_valid_o    = (state == RESP) && !owner;
  assign resp1_valid_o    = (state == RESP) &&  owner;
  assign resp0_data_o     = result;
  assign resp1_data_o     = result;
  assign owner_resp_ready = owner ? resp1_ready_i : resp0_ready_i;

  assign alu_data1_o = op_data1;
  assign alu_data2_o = op_data2;
  assign alu_ctrl_o  = op_ctrl;

  // Main FSM and datapath registers. Operands are only reloaded on a
  // request handshake so the ALU inputs stay quiet between operations.
  // The unused opcode captures zero instead of whatever the ALU returns.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state      <= IDLE;
      op_data1   <= '0;
      op_data2   <= '0;
      op_ctrl    <= ALU_AND;
      result     <= '0;
      owner      <= 1'b0;
      last_grant <= 1'b1;
      count      <= 4'd0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            op_data1   <= sel_data1;
            op_data2   <= sel_data2;
            op_ctrl    <= sel_ctrl;
            owner      <= grant;
            last_grant <= grant;
            count      <= op_latency_m1(sel_ctrl, MUL_LAT);
            state      <= EXEC;
          end
        end
        EXEC: begin
          if (count == 4'd0) begin
            result <= (op_ctrl == ALU_UNUSED) ? '0 : alu_data_i;
            state  <= RESP;
          end else begin
            count <= count - 4'd1;
          end
        end
        RESP: begin
          if (owner_resp_ready) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: self-checking bench for alu_arbiter.
// Provides a behavioural ALU on the alu_* side, runs a table of directed
// ops, hand-written tie/busy/reset sequences and randomized ops checked
// against a reference model of the expected result and latency.
module tb_alu_arbiter;
  import alu_pkg::*;

  localparam int WIDTH   = 32;
  localparam int MUL_LAT = 3;

  logic             clk_i = 1'b0;
  logic             rst_i;
  logic             req0_valid_i, req0_ready_o, resp0_valid_o, resp0_ready_i;
  logic [WIDTH-1:0] req0_data1_i, req0_data2_i, resp0_data_o;
  logic [2:0]       req0_ctrl_i;
  logic             req1_valid_i, req1_ready_o, resp1_valid_o, resp1_ready_i;
  logic [WIDTH-1:0] req1_data1_i, req1_data2_i, resp1_data_o;
  logic [2:0]       req1_ctrl_i;
  logic [WIDTH-1:0] alu_data1_o, alu_data2_o, alu_data_i;
  logic [2:0]       alu_ctrl_o;

  int compared   = 0;
  int mismatched = 0;
  logic model_last;

  typedef struct {
    bit          port;
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  ctrl;
    int          delay;
    logic [31:0] exp_data;
    int          exp_lat;
  } vec_t;

  vec_t vecs[10];

  alu_arbiter #(.WIDTH(WIDTH), .MUL_LAT(MUL_LAT)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .req0_valid_i(req0_valid_i), .req0_ready_o(req0_ready_o),
    .req0_data1_i(req0_data1_i), .req0_data2_i(req0_data2_i),
    .req0_ctrl_i(req0_ctrl_i), .resp0_valid_o(resp0_valid_o),
    .resp0_ready_i(resp0_ready_i), .resp0_data_o(resp0_data_o),
    .req1_valid_i(req1_valid_i), .req1_ready_o(req1_ready_o),
    .req1_data1_i(req1_data1_i), .req1_data2_i(req1_data2_i),
    .req1_ctrl_i(req1_ctrl_i), .resp1_valid_o(resp1_valid_o),
    .resp1_ready_i(resp1_ready_i), .resp1_data_o(resp1_data_o),
    .alu_data1_o(alu_data1_o), .alu_data2_o(alu_data2_o),
    .alu_ctrl_o(alu_ctrl_o), .alu_data_i(alu_data_i)
  );

  always #5 clk_i = ~clk_i;

  // Stand-in for the real ALU; the unused code returns a nonzero marker so
  // that the arbiter's zero substitution is observable.
  always_comb begin
    alu_data_i = 32'hDEAD_BEEF;
    case (alu_ctrl_o)
      3'b000: alu_data_i = alu_data1_o & alu_data2_o;
      3'b001: alu_data_i = $unsigned($signed(alu_data1_o) >>> alu_data2_o[4:0]);
      3'b010: alu_data_i = alu_data1_o + alu_data2_o;
      3'b011: alu_data_i = alu_data1_o << alu_data2_o[4:0];
      3'b100: alu_data_i = alu_data1_o * alu_data2_o;
      3'b110: alu_data_i = alu_data1_o - alu_data2_o;
      3'b111: alu_data_i = alu_data1_o ^ alu_data2_o;
      default: alu_data_i = 32'hDEAD_BEEF;
    endcase
  end

  // Expected result a requester should receive for an op.
  function automatic logic [31:0] ref_result(input logic [2:0] c,
                                             input logic [31:0] a,
                                             input logic [31:0] b);
    logic [63:0] prod;
    case (c)
      3'b000: return a & b;
      3'b001: return $unsigned($signed(a) >>> b[4:0]);
      3'b010: return a + b;
      3'b011: return a << b[4:0];
      3'b100: begin prod = 64'(a) * 64'(b); return prod[31:0]; end
      3'b110: return a - b;
      3'b111: return a ^ b;
      default: return 32'd0;
    endcase
  endfunction

  function automatic int ref_latency(input logic [2:0] c);
    return (c == 3'b100) ? MUL_LAT : 1;
  endfunction

  function automatic logic get_ready(input logic p);
    return p ? req1_ready_o : req0_ready_o;
  endfunction

  function automatic logic get_resp_valid(input logic p);
    return p ? resp1_valid_o : resp0_valid_o;
  endfunction

  function automatic logic [31:0] get_resp_data(input logic p);
    return p ? resp1_data_o : resp0_data_o;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic p, input logic [31:0] a,
                               input logic [31:0] b, input logic [2:0] c);
    if (p) begin
      req1_data1_i = a; req1_data2_i = b; req1_ctrl_i = c; req1_valid_i = 1'b1;
    end else begin
      req0_data1_i = a; req0_data2_i = b; req0_ctrl_i = c; req0_valid_i = 1'b1;
    end
  endtask

  task automatic drop_valid(input logic p);
    if (p) req1_valid_i = 1'b0;
    else   req0_valid_i = 1'b0;
  endtask

  task automatic set_resp_ready(input logic p, input logic v);
    if (p) resp1_ready_i = v;
    else   resp0_ready_i = v;
  endtask

  // Full single-port transaction: request, latency check, response hold
  // for 'delay' cycles with ready low, then the response handshake.
  task automatic run_op(input logic p, input logic [31:0] a, input logic [31:0] b,
                        input logic [2:0] c, input int delay,
                        input logic [31:0] exp_data, input int exp_lat);
    int n;
    @(negedge clk_i);
    applyStimulus(p, a, b, c);
    #1;
    n = 0;
    while (!get_ready(p) && n < 20) begin
      @(negedge clk_i); #1; n++;
    end
    checkOutput("req_ready", 32'(get_ready(p)), 32'd1);
    checkOutput("other_req_ready", 32'(get_ready(!p)), 32'd0);
    if (!get_ready(p)) begin
      drop_valid(p);
      return;
    end
    @(posedge clk_i); #1;
    drop_valid(p);
    model_last = p;
    @(negedge clk_i);
    checkOutput("alu_ctrl", 32'(alu_ctrl_o), 32'(c));
    checkOutput("alu_data1", alu_data1_o, a);
    n = 1;
    while (!get_resp_valid(p) && n < 40) begin
      @(negedge clk_i); n++;
    end
    checkOutput("resp_cycle", 32'(n), 32'(exp_lat + 1));
    checkOutput("resp_data", get_resp_data(p), exp_data);
    checkOutput("other_resp_valid", 32'(get_resp_valid(!p)), 32'd0);
    for (int i = 0; i < delay; i++) begin
      @(negedge clk_i);
      checkOutput("resp_hold_valid", 32'(get_resp_valid(p)), 32'd1);
      checkOutput("resp_hold_data", get_resp_data(p), exp_data);
    end
    set_resp_ready(p, 1'b1);
    @(posedge clk_i); #1;
    set_resp_ready(p, 1'b0);
    checkOutput("resp_done_valid", 32'(get_resp_valid(p)), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n;
    logic g;
    logic [31:0] ra, rb;
    logic [2:0] rc;
    logic rp;

    vecs[0] = '{1'b0, 32'd5, 32'd7, ALU_ADD, 0, 32'd12, 1};
    vecs[1] = '{1'b1, 32'd6, 32'd7, ALU_MUL, 0, 32'd42, 3};
    vecs[2] = '{1'b1, 32'd6, 32'd7, ALU_MUL, 5, 32'd42, 3};
    vecs[3] = '{1'b0, 32'd1, 32'd1, ALU_UNUSED, 0, 32'd0, 1};
    vecs[4] = '{1'b0, 32'hF0F0_F0F0, 32'h0FF0_0FF0, ALU_AND, 1, 32'h00F0_00F0, 1};
    vecs[5] = '{1'b1, 32'd3, 32'd5, ALU_SUB, 0, 32'hFFFF_FFFE, 1};
    vecs[6] = '{1'b0, 32'hAAAA_AAAA, 32'hFFFF_0000, ALU_XOR, 2, 32'h5555_AAAA, 1};
    vecs[7] = '{1'b1, 32'd1, 32'd31, ALU_SLL, 0, 32'h8000_0000, 1};
    vecs[8] = '{1'b0, 32'h8000_0000, 32'd4, ALU_SRA, 0, 32'hF800_0000, 1};
    vecs[9] = '{1'b1, 32'hFFFF_FFFF, 32'd2, ALU_MUL, 1, 32'hFFFF_FFFE, 3};

    req0_valid_i = 0; req0_data1_i = 0; req0_data2_i = 0; req0_ctrl_i = 0; resp0_ready_i = 0;
    req1_valid_i = 0; req1_data1_i = 0; req1_data2_i = 0; req1_ctrl_i = 0; resp1_ready_i = 0;
    rst_i = 1'b1;
    model_last = 1'b1;
    repeat (3) @(negedge clk_i);
    checkOutput("rst_resp0_valid", 32'(resp0_valid_o), 32'd0);
    checkOutput("rst_resp1_valid", 32'(resp1_valid_o), 32'd0);
    checkOutput("rst_alu_ctrl", 32'(alu_ctrl_o), 32'd0);
    checkOutput("rst_alu_data1", alu_data1_o, 32'd0);
    checkOutput("rst_resp_data", resp0_data_o, 32'd0);
    rst_i = 1'b0;

    $display("[TB] tie and fairness");
    resp0_ready_i = 1'b1; resp1_ready_i = 1'b1;
    @(negedge clk_i);
    applyStimulus(1'b0, 32'd10, 32'd3, ALU_SUB);
    applyStimulus(1'b1, 32'd9, 32'd4, ALU_SUB);
    for (int i = 0; i < 4; i++) begin
      #1;
      n = 0;
      while (!(req0_ready_o || req1_ready_o) && n < 20) begin
        @(negedge clk_i); #1; n++;
      end
      g = !model_last;
      checkOutput("tie_grant_ready", 32'(get_ready(g)), 32'd1);
      checkOutput("tie_other_ready", 32'(get_ready(!g)), 32'd0);
      @(posedge clk_i);
      model_last = g;
      n = 1;
      @(negedge clk_i);
      while (!get_resp_valid(g) && n < 20) begin
        @(negedge clk_i); n++;
      end
      checkOutput("tie_resp_data", get_resp_data(g), g ? 32'd5 : 32'd7);
      checkOutput("tie_other_resp_valid", 32'(get_resp_valid(!g)), 32'd0);
      @(negedge clk_i);
    end
    drop_valid(1'b0); drop_valid(1'b1);
    resp0_ready_i = 1'b0; resp1_ready_i = 1'b0;

    $display("[TB] busy blocking");
    @(negedge clk_i);
    applyStimulus(1'b0, 32'd3, 32'd4, ALU_MUL);
    #1;
    checkOutput("busy_ready0", 32'(req0_ready_o), 32'd1);
    @(posedge clk_i); #1;
    drop_valid(1'b0);
    model_last = 1'b0;
    applyStimulus(1'b1, 32'd20, 32'd22, ALU_ADD);
    n = 0;
    do begin
      @(negedge clk_i);
      checkOutput("busy_ready1_low", 32'(req1_ready_o), 32'd0);
      n++;
    end while (!resp0_valid_o && n < 20);
    checkOutput("busy_resp0_data", resp0_data_o, 32'd12);
    applyStimulus(1'b0, 32'd1, 32'd2, ALU_ADD);
    resp0_ready_i = 1'b1;
    #1;
    checkOutput("busy_resp_ready0", 32'(req0_ready_o), 32'd0);
    @(posedge clk_i); #1;
    resp0_ready_i = 1'b0;
    checkOutput("busy_grant1", 32'(req1_ready_o), 32'd1);
    checkOutput("busy_not0", 32'(req0_ready_o), 32'd0);
    drop_valid(1'b0);
    #1;
    @(posedge clk_i); #1;
    drop_valid(1'b1);
    model_last = 1'b1;
    n = 1;
    @(negedge clk_i);
    while (!resp1_valid_o && n < 20) begin
      @(negedge clk_i); n++;
    end
    checkOutput("busy_resp1_cycle", 32'(n), 32'd2);
    checkOutput("busy_resp1_data", resp1_data_o, 32'd42);
    resp1_ready_i = 1'b1;
    @(posedge clk_i); #1;
    resp1_ready_i = 1'b0;

    $display("[TB] directed table");
    for (int i = 0; i < 10; i++) begin
      run_op(vecs[i].port, vecs[i].a, vecs[i].b, vecs[i].ctrl, vecs[i].delay,
             vecs[i].exp_data, vecs[i].exp_lat);
    end

    $display("[TB] randomized ops");
    for (int i = 0; i < 30; i++) begin
      rp = 1'($urandom_range(0, 1));
      rc = 3'($urandom_range(0, 7));
      ra = $urandom;
      rb = $urandom;
      run_op(rp, ra, rb, rc, $urandom_range(0, 3), ref_result(rc, ra, rb), ref_latency(rc));
    end

    $display("[TB] reset during mul");
    @(negedge clk_i);
    applyStimulus(1'b0, 32'd6, 32'd7, ALU_MUL);
    @(posedge clk_i); #1;
    drop_valid(1'b0);
    @(posedge clk_i); #2;
    rst_i = 1'b1;
    applyStimulus(1'b1, 32'd1, 32'd1, ALU_ADD);
    #1;
    checkOutput("midrst_resp0_valid", 32'(resp0_valid_o), 32'd0);
    checkOutput("midrst_ready1", 32'(req1_ready_o), 32'd0);
    checkOutput("midrst_alu_ctrl", 32'(alu_ctrl_o), 32'd0);
    checkOutput("midrst_alu_data1", alu_data1_o, 32'd0);
    drop_valid(1'b1);
    @(negedge clk_i);
    rst_i = 1'b0;
    model_last = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk_i);
      checkOutput("postrst_no_resp", 32'({resp1_valid_o, resp0_valid_o}), 32'd0);
    end
    applyStimulus(1'b0, 32'd2, 32'd3, ALU_ADD);
    applyStimulus(1'b1, 32'd4, 32'd5, ALU_ADD);
    #1;
    checkOutput("postrst_tie_ready0", 32'(req0_ready_o), 32'd1);
    checkOutput("postrst_tie_ready1", 32'(req1_ready_o), 32'd0);
    @(posedge clk_i); #1;
    drop_valid(1'b0); drop_valid(1'b1);
    n = 1;
    @(negedge clk_i);
    while (!resp0_valid_o && n < 20) begin
      @(negedge clk_i); n++;
    end
    checkOutput("postrst_resp0_data", resp0_data_o, 32'd5);
    resp0_ready_i = 1'b1;
    @(posedge clk_i); #1;
    resp0_ready_i = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
